// File: rtl/fir2n_mac_seq.sv
// Control sequencer for a time-multiplexed fir2n datapath: flushes the sample buffer,
// accepts samples, walks every tap through one shared MAC, then flags each result.
module fir2n_mac_seq #(
  parameter int WIDTH_DATA  = 8,
  parameter int N_TAPS      = 16,
  parameter int LOG2_N_TAPS = 4,
  parameter int MAC_LAT     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH_DATA-1:0]  din,
  input  logic                   din_valid,
  output logic                   din_ready,
  output logic                   wr_en,
  output logic [LOG2_N_TAPS-1:0] wr_addr,
  output logic [WIDTH_DATA-1:0]  wr_data,
  output logic [LOG2_N_TAPS-1:0] smp_addr,
  output logic [LOG2_N_TAPS-1:0] coef_addr,
  output logic                   acc_clr,
  output logic                   acc_en,
  output logic                   out_valid,
  output logic                   busy
);

  // state/cnt name the phase the outputs will present in the coming cycle.
  // The single write cycle is issued straight from the IDLE handshake edge,
  // so it needs no state of its own.
  typedef enum logic [2:0] {FLUSH, IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [LOG2_N_TAPS-1:0] LAST_TAP   = LOG2_N_TAPS'(N_TAPS - 1);
  localparam logic [LOG2_N_TAPS-1:0] LAST_DRAIN = LOG2_N_TAPS'((MAC_LAT == 0) ? 0 : MAC_LAT - 1);
  localparam logic [LOG2_N_TAPS-1:0] ONE        = LOG2_N_TAPS'(1);

  state_t                 state, nxt_state;
  logic [LOG2_N_TAPS-1:0] cnt, nxt_cnt;
  logic [LOG2_N_TAPS-1:0] wr_ptr, nxt_ptr;

  logic                   d_din_ready, d_wr_en, d_acc_clr, d_acc_en, d_out_valid, d_busy;
  logic [LOG2_N_TAPS-1:0] d_wr_addr, d_smp_addr, d_coef_addr;
  logic [WIDTH_DATA-1:0]  d_wr_data;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    nxt_state   = state;
    nxt_cnt     = cnt;
    nxt_ptr     = wr_ptr;
    d_din_ready = 1'b0;
    d_wr_en     = 1'b0;
    d_acc_clr   = 1'b0;
    d_acc_en    = 1'b0;
    d_out_valid = 1'b0;
    d_busy      = 1'b1;
    d_wr_addr   = wr_addr;
    d_wr_data   = wr_data;
    d_smp_addr  = smp_addr;
    d_coef_addr = coef_addr;
    case (state)
      FLUSH: begin
        d_wr_en   = 1'b1;
        d_wr_addr = cnt;
        d_wr_data = '0;
        if (cnt == LAST_TAP) begin
          nxt_state = IDLE;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + ONE;
        end
      end
      IDLE: begin
        if (din_ready && din_valid) begin
          d_wr_en   = 1'b1;
          d_wr_addr = wr_ptr;
          d_wr_data = din;
          nxt_state = RUN;
          nxt_cnt   = '0;
        end else begin
          d_din_ready = 1'b1;
          d_busy      = 1'b0;
        end
      end
      RUN: begin
        d_acc_en    = 1'b1;
        d_acc_clr   = (cnt == '0);
        d_coef_addr = cnt;
        d_smp_addr  = wr_ptr - cnt;  // k=0 is the newest sample; wraps mod N_TAPS
        if (cnt == LAST_TAP) begin
          nxt_state = (MAC_LAT == 0) ? DONE : DRAIN;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + ONE;
        end
      end
      DRAIN: begin
        if (cnt == LAST_DRAIN) begin
          nxt_state = DONE;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + ONE;
        end
      end
      DONE: begin
        d_out_valid = 1'b1;
        nxt_ptr     = wr_ptr + ONE;
        nxt_state   = IDLE;
      end
      default: begin
        nxt_state = FLUSH;
        nxt_cnt   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FLUSH;
      cnt       <= '0;
      wr_ptr    <= '0;
      din_ready <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      smp_addr  <= '0;
      coef_addr <= '0;
      acc_clr   <= 1'b0;
      acc_en    <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      wr_ptr    <= nxt_ptr;
      din_ready <= d_din_ready;
      wr_en     <= d_wr_en;
      wr_addr   <= d_wr_addr;
      wr_data   <= d_wr_data;
      smp_addr  <= d_smp_addr;
      coef_addr <= d_coef_addr;
      acc_clr   <= d_acc_clr;
      acc_en    <= d_acc_en;
      out_valid <= d_out_valid;
      busy      <= d_busy;
    end
  end

endmodule

// File: tb/tb_fir2n_mac_seq.sv
// Directed bench for fir2n_mac_seq: flush, single sample timing table, back-to-back,
// pointer wrap, reset mid-RUN, and a MAC_LAT=0 instance run alongside.
module tb_fir2n_mac_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;

  logic       din_ready, wr_en, acc_clr, acc_en, out_valid, busy;
  logic [3:0] wr_addr, smp_addr, coef_addr;
  logic [7:0] wr_data;

  logic       z_din_ready, z_wr_en, z_acc_clr, z_acc_en, z_out_valid, z_busy;
  logic [3:0] z_wr_addr, z_smp_addr, z_coef_addr;
  logic [7:0] z_wr_data;

  fir2n_mac_seq dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .smp_addr(smp_addr),
    .coef_addr(coef_addr), .acc_clr(acc_clr), .acc_en(acc_en), .out_valid(out_valid),
    .busy(busy)
  );

  fir2n_mac_seq #(.MAC_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(z_din_ready),
    .wr_en(z_wr_en), .wr_addr(z_wr_addr), .wr_data(z_wr_data), .smp_addr(z_smp_addr),
    .coef_addr(z_coef_addr), .acc_clr(z_acc_clr), .acc_en(z_acc_en), .out_valid(z_out_valid),
    .busy(z_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       acc_en;
    logic       acc_clr;
    logic [3:0] coef;
    logic [3:0] smp;
    logic       out_valid;
    logic       din_ready;
    logic       busy;
  } vec_t;

  vec_t tbl [1:21];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  int acc_q[$];
  int wa_q[$];
  int wd_q[$];
  int smp_q[$];
  int ov_cnt;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one edge and settle; outputs are sampled and inputs driven here.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_zero(input string name);
    check(name, {din_ready, wr_en, wr_addr, wr_data, smp_addr, coef_addr,
                 acc_clr, acc_en, out_valid, busy}, 0);
  endtask

  task automatic do_reset(input int ncyc);
    rst = 1'b1;
    din_valid = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      check_zero($sformatf("reset_zero_%0d", i));
    end
    rst = 1'b0;
    din_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("flush_wr_en_%0d", i), wr_en, 1);
      check($sformatf("flush_wr_addr_%0d", i), wr_addr, i);
      check($sformatf("flush_wr_data_%0d", i), wr_data, 0);
      check($sformatf("flush_ctl_%0d", i), {din_ready, acc_en, out_valid, busy}, 4'b0001);
    end
    tick();
    check("post_flush_ready", din_ready, 1);
    check("post_flush_busy", busy, 0);
  endtask

  // Hold din_valid with din = first, first+1, ... until n results appear.
  task automatic run_samples(input int n, input int first);
    int idx = 0;
    int t = 0;
    acc_q.delete(); wa_q.delete(); wd_q.delete(); smp_q.delete();
    ov_cnt = 0;
    din = 8'(first);
    din_valid = 1'b1;
    while (ov_cnt < n && t < n * 40 + 40) begin
      if (din_valid && din_ready) begin
        acc_q.push_back(cyc);
        idx++;
      end
      tick();
      t++;
      if (idx == n) din_valid = 1'b0;
      else din = 8'(first + idx);
      if (wr_en) begin
        wa_q.push_back(int'(wr_addr));
        wd_q.push_back(int'(wr_data));
      end
      if (acc_en) smp_q.push_back(int'(smp_addr));
      if (out_valid) ov_cnt++;
    end
    din_valid = 1'b0;
    check("run_result_count", ov_cnt, n);
  endtask

  initial begin
    int a;
    int clr;
    int k;
    int t;

    // Expected single-sample trace for din=1 written at address 0, offset = cycles after accept.
    for (int o = 1; o <= 21; o++) begin
      tbl[o] = '{wr_en: 0, wr_addr: 0, wr_data: 0, acc_en: 0, acc_clr: 0,
                 coef: 4'd15, smp: 4'd1, out_valid: 0, din_ready: 0, busy: 1};
    end
    tbl[1].wr_en = 1; tbl[1].wr_data = 8'd1;
    for (int kk = 0; kk < 16; kk++) begin
      tbl[kk + 2].acc_en  = 1;
      tbl[kk + 2].acc_clr = (kk == 0);
      tbl[kk + 2].coef    = 4'(kk);
      tbl[kk + 2].smp     = 4'(16 - kk);
    end
    tbl[20].out_valid = 1;
    tbl[21].din_ready = 1;
    tbl[21].busy      = 0;

    // Reset / flush
    do_reset(3);

    // Single sample, table-driven; MAC_LAT=0 instance checked on the same run
    din = 8'd1;
    din_valid = 1'b1;
    check("single_ready_at_accept", din_ready, 1);
    a = cyc;
    for (int o = 1; o <= 21; o++) begin
      tick();
      din_valid = 1'b0;
      check($sformatf("single_wr_en_%0d", o), wr_en, tbl[o].wr_en);
      if (tbl[o].wr_en) begin
        check($sformatf("single_wr_addr_%0d", o), wr_addr, tbl[o].wr_addr);
        check($sformatf("single_wr_data_%0d", o), wr_data, tbl[o].wr_data);
      end
      check($sformatf("single_acc_en_%0d", o), acc_en, tbl[o].acc_en);
      check($sformatf("single_acc_clr_%0d", o), acc_clr, tbl[o].acc_clr);
      if (o >= 2) begin
        check($sformatf("single_coef_%0d", o), coef_addr, tbl[o].coef);
        check($sformatf("single_smp_%0d", o), smp_addr, tbl[o].smp);
      end
      check($sformatf("single_out_valid_%0d", o), out_valid, tbl[o].out_valid);
      check($sformatf("single_din_ready_%0d", o), din_ready, tbl[o].din_ready);
      check($sformatf("single_busy_%0d", o), busy, tbl[o].busy);
      check($sformatf("lat0_out_valid_%0d", o), z_out_valid, int'(o == 18));
      check($sformatf("lat0_din_ready_%0d", o), z_din_ready, int'(o >= 19));
    end
    check("single_elapsed", cyc - a, 21);

    // Back-to-back 5,6,7
    do_reset(1);
    run_samples(3, 5);
    if (acc_q.size() == 3 && wa_q.size() == 3 && smp_q.size() == 48) begin
      check("b2b_gap_0", acc_q[1] - acc_q[0], 21);
      check("b2b_gap_1", acc_q[2] - acc_q[1], 21);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("b2b_wr_addr_%0d", i), wa_q[i], i);
        check($sformatf("b2b_wr_data_%0d", i), wd_q[i], 5 + i);
      end
      for (int kk = 0; kk < 16; kk++)
        check($sformatf("b2b_smp3_%0d", kk), smp_q[32 + kk], (2 - kk) & 15);
    end else begin
      check("b2b_log_sizes", acc_q.size() * 10000 + wa_q.size() * 100 + smp_q.size(), 30348);
    end

    // Pointer wrap with 17 samples
    do_reset(1);
    run_samples(17, 1);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) ov_cnt++;
    end
    check("wrap_out_valid_total", ov_cnt, 17);
    if (wa_q.size() == 17 && smp_q.size() == 272) begin
      check("wrap_wr_addr_16", wa_q[16], 0);
      check("wrap_wr_addr_15", wa_q[15], 15);
      for (int kk = 0; kk < 16; kk++)
        check($sformatf("wrap_smp17_%0d", kk), smp_q[256 + kk], (0 - kk) & 15);
    end else begin
      check("wrap_log_sizes", wa_q.size() * 1000 + smp_q.size(), 17272);
    end

    // Reset at k=7 of the second sample
    do_reset(1);
    din = 8'h11;
    din_valid = 1'b1;
    clr = 0; k = 0; t = 0; ov_cnt = 0;
    while (!(clr == 2 && k == 7) && t < 200) begin
      tick();
      t++;
      if (acc_en) begin
        if (acc_clr) begin
          clr++;
          k = 0;
        end else begin
          k++;
        end
      end
      if (out_valid) ov_cnt++;
    end
    check("midrun_reached_k7", int'(clr == 2 && k == 7), 1);
    check("midrun_first_result", ov_cnt, 1);
    do_reset(1);
    run_samples(1, 8'h33);
    if (wa_q.size() >= 1) check("midrun_next_wr_addr", wa_q[0], 0);
    else check("midrun_next_write_seen", wa_q.size(), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fir2n_mac_seq.md
# fir2n_mac_seq

Sequencer for a time-multiplexed `fir2n` datapath that shares one multiply-accumulate unit across all taps. It accepts input samples through a valid/ready handshake and writes them into a circular sample buffer. For each sample it steps sample and coefficient addresses through every tap while driving the MAC accumulate controls, then flags the finished output. It sits between the sample source and the `fir2n` MAC/buffer/coefficient-ROM datapath.

## Interface
- `WIDTH_DATA`, 8, sample width.
- `N_TAPS`, 16, filter length; must equal 2**`LOG2_N_TAPS`.
- `LOG2_N_TAPS`, 4, address width for sample buffer and coefficient ROM.
- `MAC_LAT`, 2, pipeline depth of the MAC from `acc_en` to an updated accumulator; legal range 0..7.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `din`  in  WIDTH_DATA  input sample.
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  sequencer can accept a sample.
- `wr_en`  out  1  sample-buffer write strobe.
- `wr_addr`  out  LOG2_N_TAPS  sample-buffer write address.
- `wr_data`  out  WIDTH_DATA  sample-buffer write data.
- `smp_addr`  out  LOG2_N_TAPS  sample-buffer read address.
- `coef_addr`  out  LOG2_N_TAPS  coefficient ROM address.
- `acc_clr`  out  1  MAC loads the product instead of accumulating.
- `acc_en`  out  1  MAC consumes the current product.
- `out_valid`  out  1  one-cycle pulse: MAC output holds a finished filter result.
- `busy`  out  1  high in every state except IDLE.

## Operation
- All outputs are registered. When `rst` is high at an edge, every output goes to 0, `wr_ptr` goes to 0, the tap counter goes to 0, and the state goes to FLUSH.
- States and transitions:
  - **FLUSH**: writes 0 to buffer addresses 0..N_TAPS-1, one per cycle, with `wr_en`=1 and `wr_data`=0. After the last address it moves to IDLE.
  - **IDLE**: `din_ready`=1. A handshake (`din_valid` & `din_ready` at an edge) captures `din` and moves to WRITE. `din_valid` without the handshake has no effect.
  - **WRITE**: one cycle with `wr_en`=1, `wr_addr`=`wr_ptr`, `wr_data`=captured sample. Then moves to RUN.
  - **RUN**: lasts N_TAPS cycles with tap index k=0..N_TAPS-1.
    - `acc_en`=1 every cycle; `acc_clr`=1 only at k=0.
    - `coef_addr`=k.
    - `smp_addr`=(`wr_ptr`−k) mod N_TAPS, so k=0 is the newest sample. Wrap-around is natural LOG2_N_TAPS-bit modulo arithmetic.
  - **DRAIN**: MAC_LAT cycles with `acc_en`=0. Skipped when MAC_LAT=0.
  - **DONE**: `out_valid`=1 for one cycle. `wr_ptr` increments mod N_TAPS at the end of this cycle. Then moves to IDLE.
- Output values outside the listed assertions:
  - `din_ready`=0, `wr_en`=0, `acc_en`=0, `acc_clr`=0, `out_valid`=0.
  - `smp_addr` and `coef_addr` hold their last values.
- `rst` mid-operation (any state) aborts the current sample with no `out_valid`. The buffer is re-flushed and `wr_ptr` restarts at 0.

## Timing
- Reset: let R be the last edge with `rst`=1. Cycles R+1..R+N_TAPS are FLUSH; the first `din_ready`=1 is at cycle R+N_TAPS+1.
- Sample accepted in cycle A:
  - WRITE at A+1.
  - RUN at A+2..A+N_TAPS+1.
  - DRAIN at A+N_TAPS+2..A+N_TAPS+MAC_LAT+1.
  - DONE (`out_valid`) at A+N_TAPS+MAC_LAT+2.
  - `din_ready` again at A+N_TAPS+MAC_LAT+3.
- Defaults: accept at 0 → `out_valid` at 20, next accept earliest at 21. Throughput is one sample per N_TAPS+MAC_LAT+3 cycles.
- `busy` = (state ≠ IDLE), registered with the state.

## Test plan
- **Reset/flush**: assert `rst` for 3 cycles with `din_valid`=1.
  - During reset and the cycle after: all outputs 0.
  - Then 16 cycles with `wr_en`=1, `wr_addr`=0..15, `wr_data`=0.
  - Then `din_ready`=1 and `busy`=0.
- **Single sample**: `din`=1 accepted at cycle A.
  - `wr_en` at A+1 with `wr_addr`=0, `wr_data`=1.
  - `acc_clr` only at A+2; `acc_en` at A+2..A+17; `coef_addr` 0..15; `smp_addr` 0,15,14..1.
  - `out_valid` single pulse at A+20.
- **Back-to-back**: hold `din_valid`=1 with samples 5,6,7.
  - Accepts spaced exactly 21 cycles apart, written to addresses 0,1,2.
  - Third sample's RUN `smp_addr` sequence is 2,1,0,15..3.
- **Pointer wrap**: push 17 samples.
  - 17th sample is written at `wr_addr`=0.
  - Its RUN `smp_addr` sequence is 0,15..1.
  - Exactly 17 `out_valid` pulses.
- **Reset mid-RUN**: assert `rst` at k=7 of the second sample.
  - No `out_valid` for that sample; `acc_en` drops next cycle.
  - Full 16-cycle flush follows.
  - Next accepted sample is written at `wr_addr`=0.
- **MAC_LAT=0 build**: `out_valid` at A+18; `din_ready` again at A+19.
